// File: rtl/camera_i2c_config_sequencer.sv
// camera_i2c_config_sequencer
//
// Power-up / re-configuration sequencer for the D5M camera. It holds the camera in reset,
// waits for the sensor to power up, then walks an external register table and writes each
// entry as a four-byte I2C write (slave address, register address, data high, data low)
// through a byte-command engine. Done / error status is reported to the HPS.
//
// Optional feature macro: CAMCFG_DELAY_EN
//   Defined: a table entry whose register address is 8'hFF is a pure delay of
//   data * DELAY_UNIT cycles and produces no I2C traffic.
//   Undefined: 8'hFF is written like any other register address.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   start               1-cycle pulse: rerun the whole sequence (ignored while busy)
//   cfg_index           table index; the table answers combinationally on cfg_entry
//   cfg_entry           {reg_addr[23:16], data[15:0]}
//   i2c_cmd_*           byte command to the engine (valid/ready, start/stop flags, byte)
//   i2c_rsp_valid/nack  one response per accepted byte, nack qualifies valid
//   cam_reset_n         camera reset, active low
//   busy, done, error   status
//   err_index           entry that ran out of retries
module camera_i2c_config_sequencer #(
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned IDX_W          = 6,
  parameter logic [7:0]  SLAVE_ADDR     = 8'hBA,
  parameter int unsigned RESET_CYCLES   = 1000,
  parameter int unsigned POWERUP_CYCLES = 50000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned DELAY_UNIT     = 50
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [IDX_W-1:0] cfg_index,
  input  logic [23:0]      cfg_entry,
  output logic             i2c_cmd_valid,
  input  logic             i2c_cmd_ready,
  output logic             i2c_cmd_start,
  output logic             i2c_cmd_stop,
  output logic [7:0]       i2c_cmd_byte,
  input  logic             i2c_rsp_valid,
  input  logic             i2c_rsp_nack,
  output logic             cam_reset_n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index
);

  localparam logic [3:0] RST_HOLD = 4'd0;
  localparam logic [3:0] PWR_WAIT = 4'd1;
  localparam logic [3:0] FETCH    = 4'd2;
  localparam logic [3:0] SEND     = 4'd3;
  localparam logic [3:0] WAIT_RSP = 4'd4;
  localparam logic [3:0] NEXT     = 4'd5;
  localparam logic [3:0] DONE     = 4'd6;
  localparam logic [3:0] ERROR    = 4'd7;
`ifdef CAMCFG_DELAY_EN
  localparam logic [3:0] DELAY    = 4'd8;
`endif

  // One counter serves the reset hold, the power-up wait and (optionally) delay entries.
  localparam int unsigned HOLD_MAX = (RESET_CYCLES > POWERUP_CYCLES) ? RESET_CYCLES
                                                                     : POWERUP_CYCLES;
`ifdef CAMCFG_DELAY_EN
  localparam int unsigned DLY_MAX  = 65535 * DELAY_UNIT;
  localparam int unsigned CNT_MAX  = (DLY_MAX > HOLD_MAX) ? DLY_MAX : HOLD_MAX;
`else
  localparam int unsigned CNT_MAX  = HOLD_MAX;
`endif
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RTY_W    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [23:0]      entry_q, entry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;

`ifdef CAMCFG_DELAY_EN
  logic [31:0] dly_total;
  assign dly_total = 32'(cfg_entry[15:0]) * DELAY_UNIT;
`else
  // DELAY_UNIT only matters when delay entries are enabled.
  logic unused_delay_unit;
  assign unused_delay_unit = ^DELAY_UNIT;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    retry_d    = retry_q;
    entry_d    = entry_q;
    idx_d      = idx_q;
    err_idx_d  = err_idx_q;
    case (state_q)
      RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = PWR_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          state_d = (NUM_REGS > 0) ? FETCH : DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FETCH: begin
        entry_d    = cfg_entry;
        byte_cnt_d = 2'd0;
        state_d    = SEND;
`ifdef CAMCFG_DELAY_EN
        if (cfg_entry[23:16] == 8'hFF) begin
          if (dly_total == 32'd0) begin
            state_d = NEXT;
          end else begin
            // Down-counter reaches zero after exactly dly_total DELAY cycles.
            cnt_d   = CNT_W'(dly_total - 32'd1);
            state_d = DELAY;
          end
        end
`endif
      end
      SEND: begin
        if (i2c_cmd_ready) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (i2c_rsp_valid) begin
          if (!i2c_rsp_nack) begin
            if (byte_cnt_q == 2'd3) begin
              state_d = NEXT;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              state_d    = SEND;
            end
          end else if (retry_q < RTY_MAX) begin
            // The engine already closed the bus with STOP; restart the whole write.
            retry_d    = retry_q + RTY_W'(1);
            byte_cnt_d = 2'd0;
            state_d    = SEND;
          end else begin
            err_idx_d = idx_q;
            state_d   = ERROR;
          end
        end
      end
      NEXT: begin
        retry_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FETCH;
        end
      end
`ifdef CAMCFG_DELAY_EN
      DELAY: begin
        if (cnt_q == '0) begin
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      DONE, ERROR: begin
        if (start) begin
          idx_d   = '0;
          retry_d = '0;
          cnt_d   = '0;
          state_d = RST_HOLD;
        end
      end
      default: state_d = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_HOLD;
      cnt_q      <= '0;
      byte_cnt_q <= 2'd0;
      retry_q    <= '0;
      entry_q    <= '0;
      idx_q      <= '0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      retry_q    <= retry_d;
      entry_q    <= entry_d;
      idx_q      <= idx_d;
      err_idx_q  <= err_idx_d;
    end
  end

  always_comb begin
    case (byte_cnt_q)
      2'd0:    i2c_cmd_byte = SLAVE_ADDR;
      2'd1:    i2c_cmd_byte = entry_q[23:16];
      2'd2:    i2c_cmd_byte = entry_q[15:8];
      default: i2c_cmd_byte = entry_q[7:0];
    endcase
  end

  // Outputs decode straight from registered state so they are glitch-free and
  // snap to their reset values the moment reset_n falls.
  assign i2c_cmd_valid = (state_q == SEND);
  assign i2c_cmd_start = (byte_cnt_q == 2'd0);
  assign i2c_cmd_stop  = (byte_cnt_q == 2'd3);
  assign cam_reset_n   = (state_q != RST_HOLD);
  assign done          = (state_q == DONE);
  assign error         = (state_q == ERROR);
  assign busy          = !(done || error);
  assign cfg_index     = idx_q;
  assign err_index     = err_idx_q;

endmodule

// File: tb/tb_camera_i2c_config_sequencer.sv
module tb_camera_i2c_config_sequencer;

  localparam int NR    = 2;
  localparam int IW    = 6;
  localparam int RST_C = 4;
  localparam int PWR_C = 8;
  localparam int MAXR  = 1;
  localparam int DU    = 2;

  typedef struct packed {
    logic [7:0] e;
    logic [7:0] b;
    logic       s;
    logic       p;
    logic       n;
  } item_t;
  typedef logic [7:0] bq_t[$];

  logic          clk, reset_n, start;
  logic [IW-1:0] cfg_index, err_index;
  logic [23:0]   cfg_entry;
  logic          i2c_cmd_valid, i2c_cmd_ready, i2c_cmd_start, i2c_cmd_stop;
  logic [7:0]    i2c_cmd_byte;
  logic          i2c_rsp_valid, i2c_rsp_nack;
  logic          cam_reset_n, busy, done, error;

  logic [23:0] tbl[NR];
  int          plan[NR][MAXR+1];  // byte position NACKed on each attempt, 4 = all ACKed

  item_t exp_q[$];
  bq_t   log_q;
  bit    m_err;
  int    m_err_idx;

  int total = 0, bad = 0;
  int cyc = 0, low_run = 0, rise_cyc = 0, lat_exp = -1;
  bit first_seen = 0, running = 0, poke_armed = 0;
  bit pend = 0, pend_nack = 0;
  int pend_lat = 0;

  camera_i2c_config_sequencer #(
    .NUM_REGS(NR), .IDX_W(IW), .SLAVE_ADDR(8'hBA), .RESET_CYCLES(RST_C),
    .POWERUP_CYCLES(PWR_C), .MAX_RETRIES(MAXR), .DELAY_UNIT(DU)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_index(cfg_index),
    .cfg_entry(cfg_entry), .i2c_cmd_valid(i2c_cmd_valid), .i2c_cmd_ready(i2c_cmd_ready),
    .i2c_cmd_start(i2c_cmd_start), .i2c_cmd_stop(i2c_cmd_stop),
    .i2c_cmd_byte(i2c_cmd_byte), .i2c_rsp_valid(i2c_rsp_valid),
    .i2c_rsp_nack(i2c_rsp_nack), .cam_reset_n(cam_reset_n), .busy(busy), .done(done),
    .error(error), .err_index(err_index)
  );

  assign cfg_entry = (cfg_index < IW'(NR)) ? tbl[cfg_index[0]] : 24'h0;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
    end
  endtask

  function automatic bit is_delay(input logic [23:0] ent);
`ifdef CAMCFG_DELAY_EN
    return ent[23:16] == 8'hFF;
`else
    return (ent[23:16] == 8'hFF) && 1'b0;
`endif
  endfunction

  // Expected byte stream and final status, straight from the table and NACK plan.
  function automatic void build();
    logic [7:0] bytes[4];
    bit ok;
    exp_q.delete();
    m_err = 0;
    m_err_idx = 0;
    for (int e = 0; e < NR; e++) begin
      if (is_delay(tbl[e])) continue;
      ok = 0;
      bytes[0] = 8'hBA;
      bytes[1] = tbl[e][23:16];
      bytes[2] = tbl[e][15:8];
      bytes[3] = tbl[e][7:0];
      for (int a = 0; a <= MAXR; a++) begin
        for (int b = 0; b < 4; b++) begin
          exp_q.push_back('{e: 8'(e), b: bytes[b], s: (b == 0), p: (b == 3),
                            n: (plan[e][a] == b)});
          if (plan[e][a] == b) break;
        end
        if (plan[e][a] >= 4) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        m_err = 1;
        m_err_idx = e;
        break;
      end
    end
  endfunction

  // Cycles from cam_reset_n rising to the first command.
  function automatic int model_lat();
    int l = PWR_C + 1;
    for (int e = 0; e < NR; e++) begin
      if (!is_delay(tbl[e])) break;
      l += int'(tbl[e][15:0]) * DU + 2;
    end
    return l;
  endfunction

  // One cycle: sample and compare at the falling edge, then drive the engine model.
  task automatic tick();
    item_t it;
    bit rdy;
    @(negedge clk);
    cyc++;
    if (reset_n) begin
      if (!cam_reset_n) low_run++;
      else if (low_run > 0) begin
        check("rst_hold_len", low_run, RST_C);
        low_run = 0;
        rise_cyc = cyc;
      end
    end
    if (running && (exp_q.size() > 0 || pend)) check("status_mid", {busy, done, error}, 3'b100);
    check("idx_range", cfg_index < IW'(NR), 1);
    if (i2c_cmd_valid) begin
      check("one_outstanding", pend, 0);
      if (!first_seen) begin
        first_seen = 1;
        if (lat_exp >= 0) check("first_cmd_lat", cyc - rise_cyc, lat_exp);
      end
      check("cmd_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        it = exp_q[0];
        check("cmd_byte", i2c_cmd_byte, it.b);
        check("cmd_start", i2c_cmd_start, it.s);
        check("cmd_stop", i2c_cmd_stop, it.p);
        check("cmd_index", cfg_index, it.e);
      end
    end
    i2c_rsp_valid = 0;
    i2c_rsp_nack = 0;
    if (pend) begin
      if (pend_lat == 0) begin
        i2c_rsp_valid = 1;
        i2c_rsp_nack = pend_nack;
        pend = 0;
      end else pend_lat--;
    end
    rdy = ($urandom_range(0, 3) != 0);
    i2c_cmd_ready = rdy;
    if (i2c_cmd_valid && rdy && exp_q.size() > 0) begin
      it = exp_q.pop_front();
      log_q.push_back(it.b);
      pend = 1;
      pend_lat = $urandom_range(0, 3);
      pend_nack = it.n;
    end
    start = 0;
    if (poke_armed && i2c_cmd_valid) begin
      start = 1;
      poke_armed = 0;
    end
  endtask

  task automatic async_reset();
    #3 reset_n = 0;
    #1;
    check("ar_cam_reset_n", cam_reset_n, 0);
    check("ar_cmd_valid", i2c_cmd_valid, 0);
    check("ar_status", {busy, done, error}, 3'b100);
    check("ar_cfg_index", cfg_index, 0);
    check("ar_err_index", err_index, 0);
    pend = 0;
    i2c_rsp_valid = 0;
    i2c_rsp_nack = 0;
    low_run = 0;
    first_seen = 0;
    log_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic run_seq(input bit via_reset, input int want_lat, input bit poke, input int rst_at);
    bit fin = 0;
    build();
    log_q.delete();
    first_seen = 0;
    pend = 0;
    lat_exp = want_lat;
    running = 1;
    if (via_reset) begin
      @(posedge clk);
      #1 reset_n = 1;
    end else begin
      start = 1;
      tick();
      check("start_drops_cam_reset", cam_reset_n, 0);
    end
    poke_armed = poke;
    for (int i = 0; i < 1500; i++) begin
      if (done || error) begin
        fin = 1;
        break;
      end
      if (i == rst_at) begin
        async_reset();
        build();
      end
      tick();
    end
    running = 0;
    poke_armed = 0;
    check("run_finished", fin, 1);
    check("end_done", done, !m_err);
    check("end_error", error, m_err);
    check("end_busy", busy, 0);
    if (m_err) check("end_err_index", err_index, m_err_idx);
    check("exp_drained", exp_q.size(), 0);
    check("end_cam_reset_n", cam_reset_n, 1);
    repeat (8) tick();
    check("idle_no_cmd", i2c_cmd_valid, 0);
    exp_q.delete();
  endtask

  task automatic check_log(input string nm, input bq_t want);
    check({nm, "_len"}, log_q.size(), want.size());
    for (int i = 0; i < want.size() && i < log_q.size(); i++) check(nm, log_q[i], want[i]);
  endtask

  task automatic clear_plan();
    for (int e = 0; e < NR; e++)
      for (int a = 0; a <= MAXR; a++) plan[e][a] = 4;
  endtask

  initial begin
    bq_t w;
    int r_at;
    reset_n = 0;
    start = 0;
    i2c_cmd_ready = 0;
    i2c_rsp_valid = 0;
    i2c_rsp_nack = 0;
    tbl[0] = 24'h200000;
    tbl[1] = 24'h090797;
    clear_plan();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cam_reset_n", cam_reset_n, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cmd_valid", i2c_cmd_valid, 0);
    check("rst_cfg_index", cfg_index, 0);
    check("rst_err_index", err_index, 0);

    // Clean pass through both entries.
    run_seq(1, 9, 0, -1);
    w = '{8'hBA, 8'h20, 8'h00, 8'h00, 8'hBA, 8'h09, 8'h07, 8'h97};
    check_log("all_ack_bytes", w);

    // One NACK on entry 0's first data byte.
    plan[0][0] = 2;
    run_seq(0, 9, 0, -1);
    w = '{8'hBA, 8'h20, 8'h00, 8'hBA, 8'h20, 8'h00, 8'h00, 8'hBA, 8'h09, 8'h07, 8'h97};
    check_log("retry_bytes", w);

    // Entry 1 register-address byte NACKed on both attempts.
    clear_plan();
    plan[1][0] = 1;
    plan[1][1] = 1;
    run_seq(0, 9, 0, -1);
    w = '{8'hBA, 8'h20, 8'h00, 8'h00, 8'hBA, 8'h09, 8'hBA, 8'h09};
    check_log("error_bytes", w);
    check("error_lit_idx", err_index, 1);
    check("error_lit_flag", error, 1);

    // Restart out of ERROR, with a start pulse during SEND that must be ignored.
    clear_plan();
    run_seq(0, 9, 1, -1);
    w = '{8'hBA, 8'h20, 8'h00, 8'h00, 8'hBA, 8'h09, 8'h07, 8'h97};
    check_log("rerun_bytes", w);
    check("rerun_done", done, 1);

    // Register address 8'hFF entry.
    tbl[0] = 24'hFF0003;
`ifdef CAMCFG_DELAY_EN
    run_seq(0, 17, 0, -1);
    w = '{8'hBA, 8'h09, 8'h07, 8'h97};
`else
    run_seq(0, 9, 0, -1);
    w = '{8'hBA, 8'hFF, 8'h00, 8'h03, 8'hBA, 8'h09, 8'h07, 8'h97};
`endif
    check_log("ff_entry_bytes", w);

    // Randomized tables, NACK plans and mid-run resets.
    for (int r = 0; r < 20; r++) begin
      for (int e = 0; e < NR; e++) begin
        logic [7:0] a;
        a = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 4) == 0) a = 8'hFF;
        tbl[e] = {a, (a == 8'hFF) ? 16'($urandom_range(0, 4)) : 16'($urandom_range(0, 65535))};
        for (int k = 0; k <= MAXR; k++)
          plan[e][k] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 4;
      end
      r_at = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 40) : -1;
      run_seq(0, model_lat(), $urandom_range(0, 1), r_at);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
